// File: rtl/time_set_pkg.sv
// Shared types and constants for the digital-clock time-setting controller.
// Holds the FSM state encoding, button indices and the field-select helper.
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_e;

  localparam int NBTN  = 5;
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  // Blink bit layout: [0]=sec, [1]=min, [2]=hour.
  function automatic logic [2:0] field_mask(input state_e s);
    case (s)
      SET_H:   field_mask = 3'b100;
      SET_M:   field_mask = 3'b010;
      SET_S:   field_mask = 3'b001;
      default: field_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Signal bundle between the button pins, the time-setting controller and the
// counter/display stages.
interface time_set_ctrl_if;
  // No valid/ready pair here: btn is a raw asynchronous level, and every
  // output is a plain registered level or a one-cycle enable that the
  // consumer must take in the cycle it is high (there is no back-pressure).
  logic [4:0] btn;
  logic       run_en;
  logic [1:0] inc_p;
  logic [1:0] dec_p;
  logic       clr_s;
  logic [1:0] mode;
  logic [2:0] blink;

  modport master (
    input  btn,
    output run_en, inc_p, dec_p, clr_s, mode, blink
  );

  modport slave (
    output btn,
    input  run_en, inc_p, dec_p, clr_s, mode, blink
  );
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, counter debounce and rising-edge press pulse.
// dout is the debounced level; press is high for one cycle per debounced rise.
module btn_debounce #(
  parameter int N = 999_999
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic press
);

  localparam int CW = (N < 1) ? 1 : $clog2(N + 1);

  logic          s1_q, s2_q, db_q, prev_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      prev_q  <= db_q;
      press_q <= db_q & ~prev_q;
      // The level only flips after N+1 consecutive disagreeing samples.
      if (s2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(N)) begin
        cnt_q <= '0;
        db_q  <= s2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dout  = db_q;
  assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced buttons drive a RUN/SET_H/SET_M/SET_S FSM
// that emits run-enable, inc/dec/clear pulses with auto-repeat, and a blink mask.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DB_N    = 999_999,
  parameter int HOLD_N  = 49_999_999,
  parameter int REP_N   = 9_999_999,
  parameter int BLINK_N = 24_999_999
) (
  input logic             clk,
  input logic             reset,
  time_set_ctrl_if.master bus
);

  localparam int REP_MAX = (HOLD_N > REP_N) ? HOLD_N : REP_N;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam int BW      = $clog2(BLINK_N + 1);

  state_e          state_q, state_d;
  logic [NBTN-1:0] db, press;
  logic            c_p, l_p, r_p, u_p, d_p, nav, held, fire, u_ev, d_ev;
  logic            run_en_q, clr_q, clr_d;
  logic [1:0]      inc_q, inc_d, dec_q, dec_d;
  logic [2:0]      blink_q;
  logic            rep_act_q, rep_act_d, rep_up_q, rep_up_d, rep_ph_q, rep_ph_d;
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            bph_q, bph_d;

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    btn_debounce #(.N(DB_N)) u_db (
      .clk   (clk),
      .reset (reset),
      .din   (bus.btn[i]),
      .dout  (db[i]),
      .press (press[i])
    );
  end

  // Same-cycle presses resolve C > L > R > U > D; losers are dropped.
  assign nav  = press[BTN_C] | press[BTN_L] | press[BTN_R];
  assign c_p  = press[BTN_C];
  assign l_p  = press[BTN_L] & ~press[BTN_C];
  assign r_p  = press[BTN_R] & ~press[BTN_C] & ~press[BTN_L];
  assign u_p  = press[BTN_U] & ~nav;
  assign d_p  = press[BTN_D] & ~nav & ~press[BTN_U];

  assign held = rep_up_q ? db[BTN_U] : db[BTN_D];
  assign fire = rep_act_q & held &
                (rep_cnt_q == (rep_ph_q ? RW'(REP_N) : RW'(HOLD_N)));
  assign u_ev = u_p | (fire &  rep_up_q & ~nav & ~press[BTN_D]);
  assign d_ev = d_p | (fire & ~rep_up_q & ~nav & ~press[BTN_U]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      run_en_q  <= 1'b1;
      inc_q     <= '0;
      dec_q     <= '0;
      clr_q     <= 1'b0;
      blink_q   <= '0;
      rep_act_q <= 1'b0;
      rep_up_q  <= 1'b0;
      rep_ph_q  <= 1'b0;
      rep_cnt_q <= '0;
      bcnt_q    <= '0;
      bph_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_en_q  <= (state_d == RUN);
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      clr_q     <= clr_d;
      blink_q   <= field_mask(state_d) & {3{bph_d}};
      rep_act_q <= rep_act_d;
      rep_up_q  <= rep_up_d;
      rep_ph_q  <= rep_ph_d;
      rep_cnt_q <= rep_cnt_d;
      bcnt_q    <= bcnt_d;
      bph_q     <= bph_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:   if (c_p) state_d = SET_H;
      SET_H: if (c_p | r_p) state_d = SET_M; else if (l_p) state_d = SET_S;
      SET_M: if (c_p | r_p) state_d = SET_S; else if (l_p) state_d = SET_H;
      SET_S: if (c_p) state_d = RUN;
             else if (r_p) state_d = SET_H;
             else if (l_p) state_d = SET_M;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    inc_d = '0;
    dec_d = '0;
    clr_d = 1'b0;
    case (state_q)
      SET_H:   begin inc_d[1] = u_ev; dec_d[1] = d_ev; end
      SET_M:   begin inc_d[0] = u_ev; dec_d[0] = d_ev; end
      SET_S:   clr_d = u_p | d_p;
      default: ;
    endcase
  end

  // Repeat counter holds cycles since the last pulse; first gap HOLD_N, then REP_N.
  always_comb begin
    rep_act_d = rep_act_q;
    rep_up_d  = rep_up_q;
    rep_ph_d  = rep_ph_q;
    rep_cnt_d = rep_cnt_q;
    if (state_d != state_q) begin
      rep_act_d = 1'b0;
      rep_ph_d  = 1'b0;
      rep_cnt_d = '0;
    end else if ((u_p | d_p) && (state_q == SET_H || state_q == SET_M)) begin
      rep_act_d = 1'b1;
      rep_up_d  = u_p;
      rep_ph_d  = 1'b0;
      rep_cnt_d = RW'(1);
    end else if (rep_act_q && !held) begin
      rep_act_d = 1'b0;
      rep_ph_d  = 1'b0;
      rep_cnt_d = '0;
    end else if (fire) begin
      rep_ph_d  = 1'b1;
      rep_cnt_d = RW'(1);
    end else if (rep_act_q) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_comb begin
    bcnt_d = bcnt_q + 1'b1;
    bph_d  = bph_q;
    if (state_d != state_q) begin
      bcnt_d = '0;
      bph_d  = 1'b0;
    end else if (bcnt_q == BW'(BLINK_N)) begin
      bcnt_d = '0;
      bph_d  = ~bph_q;
    end
  end

  assign bus.run_en = run_en_q;
  assign bus.inc_p  = inc_q;
  assign bus.dec_p  = dec_q;
  assign bus.clr_s  = clr_q;
  assign bus.mode   = state_q;
  assign bus.blink  = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl with short debounce/repeat/blink periods.
// Pulse outputs are matched against an expected queue; levels are checked directly.
module tb_time_set_ctrl;
  import time_set_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [4:0] exp_q[$];
  logic [4:0] ev;
  logic [4:0] exp_w;

  time_set_ctrl_if bus();

  time_set_ctrl #(
    .DB_N   (3),
    .HOLD_N (20),
    .REP_N  (5),
    .BLINK_N(7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int idx);
    bus.btn[idx] = 1'b1;
    tick(12);
    bus.btn[idx] = 1'b0;
    tick(12);
  endtask

  task automatic expect_pulse(input logic [4:0] w);
    exp_q.push_back(w);
  endtask

  // Pulse word layout: {clr_s, dec_p[1:0], inc_p[1:0]}.
  always @(negedge clk) begin
    if (!reset) begin
      ev = {bus.clr_s, bus.dec_p, bus.inc_p};
      if (ev != 5'd0) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_pulse", ev, 5'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check_eq("pulse", ev, exp_w);
        end
      end
    end
  end

  initial begin
    bus.btn = '0;
    reset   = 1'b1;
    tick(3);
    check_eq("rst_run_en", bus.run_en, 1);
    check_eq("rst_mode", bus.mode, RUN);
    check_eq("rst_blink", bus.blink, 0);
    check_eq("rst_pulses", {bus.clr_s, bus.dec_p, bus.inc_p}, 0);
    reset = 1'b0;
    tick(2);

    tap(BTN_U); tap(BTN_D); tap(BTN_L); tap(BTN_R);
    check_eq("run_ignore_mode", bus.mode, RUN);
    check_eq("run_ignore_run_en", bus.run_en, 1);

    // Bouncing C, then a stable level: one press, run_en falls 8 cycles later.
    for (int i = 0; i < 5; i++) begin
      bus.btn[BTN_C] = 1'b1; tick(2);
      bus.btn[BTN_C] = 1'b0; tick(2);
    end
    bus.btn[BTN_C] = 1'b1;
    tick(7);
    check_eq("bounce_run_en_before", bus.run_en, 1);
    tick(1);
    check_eq("bounce_run_en_after", bus.run_en, 0);
    check_eq("bounce_mode", bus.mode, SET_H);
    tick(15);
    bus.btn[BTN_C] = 1'b0;
    tick(12);
    check_eq("bounce_once", bus.mode, SET_H);

    tap(BTN_C); check_eq("cyc_m", bus.mode, SET_M); check_eq("cyc_m_run", bus.run_en, 0);
    tap(BTN_C); check_eq("cyc_s", bus.mode, SET_S); check_eq("cyc_s_run", bus.run_en, 0);
    tap(BTN_C); check_eq("cyc_run", bus.mode, RUN); check_eq("cyc_run_en", bus.run_en, 1);
    tap(BTN_C); check_eq("cyc_h", bus.mode, SET_H); check_eq("cyc_h_run", bus.run_en, 0);
    tap(BTN_L); check_eq("l_in_h", bus.mode, SET_S);
    tap(BTN_R); check_eq("r_in_s", bus.mode, SET_H);

    expect_pulse(5'b00010); tap(BTN_U);
    expect_pulse(5'b01000); tap(BTN_D);
    tap(BTN_R); check_eq("r_in_h", bus.mode, SET_M);
    expect_pulse(5'b00001); tap(BTN_U);
    expect_pulse(5'b00100); tap(BTN_D);
    tap(BTN_L); check_eq("l_in_m", bus.mode, SET_H);
    tap(BTN_R); tap(BTN_C); check_eq("c_in_m", bus.mode, SET_S);
    expect_pulse(5'b10000); tap(BTN_D);
    expect_pulse(5'b10000); tap(BTN_U);
    check_eq("set_q_empty", exp_q.size(), 0);

    tap(BTN_C); tap(BTN_C); tap(BTN_R);
    check_eq("rep_mode", bus.mode, SET_M);
    for (int i = 0; i < 7; i++) expect_pulse(5'b00001);
    bus.btn[BTN_U] = 1'b1;
    tick(50);
    bus.btn[BTN_U] = 1'b0;
    tick(20);
    check_eq("rep_q_empty", exp_q.size(), 0);

    // Reset while U is held in SET_M, after its press pulse went out.
    expect_pulse(5'b00001);
    bus.btn[BTN_U] = 1'b1;
    tick(10);
    reset = 1'b1;
    #1;
    check_eq("midrst_mode", bus.mode, RUN);
    check_eq("midrst_run_en", bus.run_en, 1);
    check_eq("midrst_blink", bus.blink, 0);
    check_eq("midrst_pulses", {bus.clr_s, bus.dec_p, bus.inc_p}, 0);
    tick(2);
    bus.btn[BTN_U] = 1'b0;
    reset = 1'b0;
    tick(30);
    check_eq("postrst_mode", bus.mode, RUN);
    check_eq("postrst_q_empty", exp_q.size(), 0);

    tap(BTN_C);
    check_eq("prio_pre_mode", bus.mode, SET_H);
    bus.btn[BTN_C] = 1'b1;
    bus.btn[BTN_U] = 1'b1;
    for (int i = 0; i < 20 && bus.mode != SET_M; i++) tick(1);
    check_eq("prio_mode", bus.mode, SET_M);
    check_eq("blink_ph0_start", bus.blink, 3'b000);
    bus.btn[BTN_C] = 1'b0;
    bus.btn[BTN_U] = 1'b0;
    tick(7);
    check_eq("blink_ph0_end", bus.blink, 3'b000);
    tick(1);
    check_eq("blink_ph1_start", bus.blink, 3'b010);
    tick(7);
    check_eq("blink_ph1_end", bus.blink, 3'b010);
    tick(1);
    check_eq("blink_ph0_again", bus.blink, 3'b000);
    tick(20);
    check_eq("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
